// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR mode type, default tap constants and tap legality check
package lfsr_pkg;

    typedef enum logic {
        LFSR_FIB = 1'b0,
        LFSR_GAL = 1'b1
    } lfsr_mode_t;

    // Fibonacci masks: bit i set means stage i feeds the XOR.
    // Galois masks: polynomial coefficients below the x^WIDTH term.
    // Each pair describes the same maximal-length polynomial.
    localparam logic [3:0]  FIB_TAPS_4  = 4'b1100;          // x^4+x^3+1
    localparam logic [3:0]  GAL_POLY_4  = 4'b1001;
    localparam logic [7:0]  FIB_TAPS_8  = 8'hB8;            // x^8+x^6+x^5+x^4+1
    localparam logic [7:0]  GAL_POLY_8  = 8'h71;
    localparam logic [15:0] FIB_TAPS_16 = 16'hB400;         // x^16+x^14+x^13+x^11+1
    localparam logic [15:0] GAL_POLY_16 = 16'h6801;
    localparam logic [31:0] FIB_TAPS_32 = 32'h8020_0003;    // x^32+x^22+x^2+x+1
    localparam logic [31:0] GAL_POLY_32 = 32'h0040_0007;

    // The top stage must feed back in Fibonacci form and the constant
    // term must be present in Galois form, otherwise the register degenerates.
    function automatic logic taps_legal(input int width, input logic [31:0] fib,
                                        input logic [31:0] gal);
        return (((fib >> (width - 1)) & 32'd1) != 32'd0) && gal[0];
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - combinational next-state function for Fibonacci and Galois LFSRs
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] state,
    input  lfsr_mode_t       mode,
    input  logic [WIDTH-1:0] fib_taps,
    input  logic [WIDTH-1:0] gal_poly,
    output logic [WIDTH-1:0] next
);

    // Fibonacci shifts in the XOR of tapped stages; Galois folds the poly in on carry-out.
    always_comb begin
        next = '0;
        if (mode == LFSR_FIB) begin
            next = {state[WIDTH-2:0], ^(state & fib_taps)};
        end else begin
            next = (state << 1) ^ (state[WIDTH-1] ? gal_poly : '0);
        end
    end

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - LFSR with mode select, seed load, lockup flag and period measurement (option: LFSR_LOCKUP_RECOVER_EN)
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] FIB_TAPS     = 4'b1100,
    parameter logic [WIDTH-1:0] GAL_POLY     = 4'b1001,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 4'b0001
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             load,
    input  logic             enable,
    input  logic             select,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] out,
    output logic             serial_out,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             lockup
);

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be in 3..32");
    end
    if (!taps_legal(WIDTH, 32'(FIB_TAPS), 32'(GAL_POLY))) begin : g_bad_taps
        $error("lfsr_gen: FIB_TAPS needs its top bit and GAL_POLY needs bit 0");
    end
    if (DEFAULT_SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: DEFAULT_SEED must be nonzero");
    end

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] base_count;
    logic             at_seed;
    lfsr_mode_t       mode;
    lfsr_mode_t       prev_mode;

    assign mode = lfsr_mode_t'(select);

    lfsr_next #(.WIDTH(WIDTH)) u_next (
        .state    (state),
        .mode     (mode),
        .fib_taps (FIB_TAPS),
        .gal_poly (GAL_POLY),
        .next     (nxt)
    );

    // A mode switch restarts the measurement, so this step counts from zero.
    assign base_count = (mode != prev_mode) ? '0 : count;
    assign at_seed    = (nxt == seed_q);

    // Main state, seed, step counter and period measurement.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state        <= DEFAULT_SEED;
            seed_q       <= DEFAULT_SEED;
            count        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            wrap         <= 1'b0;
            prev_mode    <= LFSR_FIB;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                state        <= seed_in;
                seed_q       <= seed_in;
                count        <= '0;
                period_valid <= 1'b0;
            end else if (enable) begin
                prev_mode <= mode;
`ifdef LFSR_LOCKUP_RECOVER_EN
                if (state == '0) begin
                    state        <= DEFAULT_SEED;
                    seed_q       <= DEFAULT_SEED;
                    count        <= '0;
                    period_valid <= 1'b0;
                end else
`endif
                begin
                    state <= nxt;
                    if (at_seed) begin
                        wrap         <= 1'b1;
                        period       <= base_count + 1'b1;
                        period_valid <= 1'b1;
                        count        <= '0;
                    end else if (base_count != '1) begin
                        count <= base_count + 1'b1;
                    end else begin
                        count <= base_count;
                    end
                end
            end
        end
    end

    assign out        = state;
    assign serial_out = state[WIDTH-1];
    assign lockup     = (state == '0);

endmodule
